// File: rtl/regfile_ctrl_pkg.sv
// Shared types and constants for the register-file writeback arbiter.
// Optional feature macro: REGFILE_WB_BYPASS_EN (commit-to-stall bypass).
package regfile_ctrl_pkg;

    localparam int XLEN          = 32;
    localparam int REG_AW        = 5;
    localparam int NUM_REGS      = 32;
    localparam int WB_FIFO_DEPTH = 2;

    // Which writeback source owns the register-file write port this cycle.
    typedef enum logic [1:0] {
        NONE = 2'd0,
        ALU  = 2'd1,
        MEM  = 2'd2
    } commit_src_e;

    // One queued load writeback.
    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   data;
    } wb_entry_t;

    // One-hot mask for a register index; x0 never maps to a bit.
    function automatic logic [NUM_REGS-1:0] reg_mask(input logic [REG_AW-1:0] idx);
        logic [NUM_REGS-1:0] m;
        m = '0;
        if (idx != '0) begin
            m[idx] = 1'b1;
        end else begin
            m = '0;
        end
        return m;
    endfunction

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Issue, writeback, register-file write and status signals of the arbiter.
interface regfile_wb_arbiter_if;
    import regfile_ctrl_pkg::*;

    logic                issue_valid;
    logic [REG_AW-1:0]   issue_rd;
    logic [REG_AW-1:0]   issue_rs1;
    logic [REG_AW-1:0]   issue_rs2;
    logic                stall;

    logic                alu_wb_valid;
    logic [REG_AW-1:0]   alu_wb_rd;
    logic [XLEN-1:0]     alu_wb_data;

    logic                mem_wb_valid;
    logic [REG_AW-1:0]   mem_wb_rd;
    logic [XLEN-1:0]     mem_wb_data;
    logic                mem_wb_ready;

    logic                WriteEnable;
    logic [REG_AW-1:0]   rd;
    logic [XLEN-1:0]     data;

    logic [NUM_REGS-1:0] busy;
    logic                sb_err;

    // Pipeline / environment side.
    modport master (
        output issue_valid, issue_rd, issue_rs1, issue_rs2,
        output alu_wb_valid, alu_wb_rd, alu_wb_data,
        output mem_wb_valid, mem_wb_rd, mem_wb_data,
        input  stall, mem_wb_ready, WriteEnable, rd, data, busy, sb_err
    );

    // Arbiter side.
    modport slave (
        input  issue_valid, issue_rd, issue_rs1, issue_rs2,
        input  alu_wb_valid, alu_wb_rd, alu_wb_data,
        input  mem_wb_valid, mem_wb_rd, mem_wb_data,
        output stall, mem_wb_ready, WriteEnable, rd, data, busy, sb_err
    );

endinterface

// File: rtl/wb_fifo.sv
// Small synchronous FIFO for queued load writebacks; full/empty come
// straight from the registered occupancy count.
module wb_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 37
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    // Pointer advance with wrap for non-power-of-two depths.
    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        if (p == PTR_LAST) begin
            return '0;
        end else begin
            return p + AW'(1);
        end
    endfunction

    assign full      = (count_r == CNT_FULL);
    assign empty     = (count_r == '0);
    assign push_ok_s = push & ~full;
    assign pop_ok_s  = pop & ~empty;
    assign rdata     = mem_r[rd_ptr_r];

    // Pointers and occupancy; a pop never frees room for a same-cycle push.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= ptr_inc(wr_ptr_r);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage; contents are don't-care while the count says empty.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= wdata;
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file writeback arbiter with busy-bit scoreboard.
// ALU writebacks have fixed priority over queued load writebacks.
// Optional macro REGFILE_WB_BYPASS_EN lets this cycle's commit clear a
// busy bit early for the stall check.
module regfile_wb_arbiter
    import regfile_ctrl_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    regfile_wb_arbiter_if.slave bus
);

    localparam int EW = REG_AW + XLEN;

    logic                fifo_full_s;
    logic                fifo_empty_s;
    logic                fifo_push_s;
    logic                fifo_pop_s;
    logic [EW-1:0]       fifo_wdata_s;
    logic [EW-1:0]       fifo_rdata_s;
    wb_entry_t           head_s;

    commit_src_e         src_s;
    logic                commit_v_s;
    logic [REG_AW-1:0]   commit_rd_s;
    logic [XLEN-1:0]     commit_data_s;

    logic [NUM_REGS-1:0] busy_r;
    logic [NUM_REGS-1:0] busy_eff_s;
    logic [NUM_REGS-1:0] set_mask_s;
    logic [NUM_REGS-1:0] clr_mask_s;
    logic                stall_s;
    logic                accept_s;

    logic                we_r;
    logic [REG_AW-1:0]   rd_r;
    logic [XLEN-1:0]     data_r;
    logic                sb_err_r;

    assign fifo_wdata_s = {bus.mem_wb_rd, bus.mem_wb_data};
    assign fifo_push_s  = bus.mem_wb_valid & ~fifo_full_s;
    assign head_s       = fifo_rdata_s;

    wb_fifo #(
        .DEPTH (WB_FIFO_DEPTH),
        .WIDTH (EW)
    ) u_wb_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push_s),
        .wdata (fifo_wdata_s),
        .pop   (fifo_pop_s),
        .rdata (fifo_rdata_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s)
    );

    // Pick this cycle's commit source: ALU first, then the load queue head.
    always_comb begin
        src_s         = NONE;
        commit_v_s    = 1'b0;
        commit_rd_s   = '0;
        commit_data_s = '0;
        if (bus.alu_wb_valid) begin
            src_s = ALU;
        end else if (!fifo_empty_s) begin
            src_s = MEM;
        end else begin
            src_s = NONE;
        end
        case (src_s)
            ALU: begin
                commit_v_s    = 1'b1;
                commit_rd_s   = bus.alu_wb_rd;
                commit_data_s = bus.alu_wb_data;
            end
            MEM: begin
                commit_v_s    = 1'b1;
                commit_rd_s   = head_s.rd;
                commit_data_s = head_s.data;
            end
            default: begin
                commit_v_s    = 1'b0;
                commit_rd_s   = '0;
                commit_data_s = '0;
            end
        endcase
    end

    assign fifo_pop_s = (src_s == MEM);
    assign clr_mask_s = commit_v_s ? reg_mask(commit_rd_s) : '0;

    // Hazard check on operands and destination; x0 never stalls.
    always_comb begin
`ifdef REGFILE_WB_BYPASS_EN
        busy_eff_s = busy_r & ~clr_mask_s;
`else
        busy_eff_s = busy_r;
`endif
        stall_s = bus.issue_valid &
                  (((bus.issue_rs1 != '0) & busy_eff_s[bus.issue_rs1]) |
                   ((bus.issue_rs2 != '0) & busy_eff_s[bus.issue_rs2]) |
                   ((bus.issue_rd  != '0) & busy_eff_s[bus.issue_rd]));
        accept_s = bus.issue_valid & ~stall_s;
        if (accept_s) begin
            set_mask_s = reg_mask(bus.issue_rd);
        end else begin
            set_mask_s = '0;
        end
    end

    // Scoreboard: commit clears, accepted issue sets, set wins on overlap.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_r <= '0;
        end else begin
            busy_r <= (busy_r & ~clr_mask_s) | set_mask_s;
        end
    end

    // Sticky flag for a write to a register nobody was waiting on.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sb_err_r <= 1'b0;
        end else begin
            sb_err_r <= sb_err_r |
                        (commit_v_s & (commit_rd_s != '0) & ~busy_r[commit_rd_s]);
        end
    end

    // Register-file write port; rd/data hold when nothing is written.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            we_r   <= 1'b0;
            rd_r   <= '0;
            data_r <= '0;
        end else begin
            we_r <= commit_v_s & (commit_rd_s != '0);
            if (commit_v_s && (commit_rd_s != '0)) begin
                rd_r   <= commit_rd_s;
                data_r <= commit_data_s;
            end
        end
    end

    assign bus.stall        = stall_s;
    assign bus.mem_wb_ready = ~fifo_full_s;
    assign bus.WriteEnable  = we_r;
    assign bus.rd           = rd_r;
    assign bus.data         = data_r;
    assign bus.busy         = busy_r;
    assign bus.sb_err       = sb_err_r;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: table of per-cycle stimulus,
// a reference model of scoreboard/queue behaviour, and an expected-write queue.
module tb_regfile_wb_arbiter;
    import regfile_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    regfile_wb_arbiter_if bus();

    regfile_wb_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic        iv;
        logic [4:0]  ird;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        av;
        logic [4:0]  ard;
        logic [31:0] ad;
        logic        mv;
        logic [4:0]  mrd;
        logic [31:0] md;
    } vec_t;

    vec_t vecs[$];

    int checks   = 0;
    int failures = 0;

    logic [31:0] m_busy;
    logic        m_err;
    logic [4:0]  m_rd;
    logic [31:0] m_data;
    logic [36:0] m_fifo[$];
    logic [36:0] exp_q[$];

    function automatic vec_t mk(input logic iv, input logic [4:0] ird,
                                input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic av, input logic [4:0] ard, input logic [31:0] ad,
                                input logic mv, input logic [4:0] mrd, input logic [31:0] md);
        vec_t v;
        v.iv = iv; v.ird = ird; v.rs1 = rs1; v.rs2 = rs2;
        v.av = av; v.ard = ard; v.ad = ad;
        v.mv = mv; v.mrd = mrd; v.md = md;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic apply(input vec_t v);
        bus.issue_valid  = v.iv;
        bus.issue_rd     = v.ird;
        bus.issue_rs1    = v.rs1;
        bus.issue_rs2    = v.rs2;
        bus.alu_wb_valid = v.av;
        bus.alu_wb_rd    = v.ard;
        bus.alu_wb_data  = v.ad;
        bus.mem_wb_valid = v.mv;
        bus.mem_wb_rd    = v.mrd;
        bus.mem_wb_data  = v.md;
    endtask

    task automatic model_reset();
        m_busy = 32'd0;
        m_err  = 1'b0;
        m_rd   = 5'd0;
        m_data = 32'd0;
        m_fifo.delete();
        exp_q.delete();
    endtask

    // One clock cycle: check combinational outputs, advance the model, check registered outputs.
    task automatic tick();
        logic        sel_v;
        logic [4:0]  c_rd;
        logic [31:0] c_data;
        logic [31:0] eff;
        logic        st;
        logic        ready;
        logic        acc;
        logic [36:0] w;
        @(negedge clk);
        sel_v  = 1'b0;
        c_rd   = 5'd0;
        c_data = 32'd0;
        if (bus.alu_wb_valid) begin
            sel_v  = 1'b1;
            c_rd   = bus.alu_wb_rd;
            c_data = bus.alu_wb_data;
        end else if (m_fifo.size() > 0) begin
            sel_v = 1'b1;
            {c_rd, c_data} = m_fifo[0];
        end
        eff = m_busy;
`ifdef REGFILE_WB_BYPASS_EN
        if (sel_v && c_rd != 5'd0) eff[c_rd] = 1'b0;
`endif
        st = bus.issue_valid && ((bus.issue_rs1 != 5'd0 && eff[bus.issue_rs1]) ||
                                 (bus.issue_rs2 != 5'd0 && eff[bus.issue_rs2]) ||
                                 (bus.issue_rd  != 5'd0 && eff[bus.issue_rd]));
        chk("stall", {31'd0, bus.stall}, {31'd0, st});
        ready = (m_fifo.size() < 2);
        chk("mem_wb_ready", {31'd0, bus.mem_wb_ready}, {31'd0, ready});
        acc = bus.issue_valid && !st;
        if (!bus.alu_wb_valid && m_fifo.size() > 0) m_fifo.delete(0);
        if (bus.mem_wb_valid && ready) m_fifo.push_back({bus.mem_wb_rd, bus.mem_wb_data});
        if (sel_v && c_rd != 5'd0) begin
            if (!m_busy[c_rd]) m_err = 1'b1;
            m_busy[c_rd] = 1'b0;
            exp_q.push_back({c_rd, c_data});
            m_rd   = c_rd;
            m_data = c_data;
        end
        if (acc && bus.issue_rd != 5'd0) m_busy[bus.issue_rd] = 1'b1;
        @(posedge clk);
        #1;
        chk("WriteEnable", {31'd0, bus.WriteEnable}, {31'd0, (exp_q.size() != 0)});
        if (exp_q.size() != 0) begin
            w = exp_q.pop_front();
            chk("write_rd", {27'd0, bus.rd}, {27'd0, w[36:32]});
            chk("write_data", bus.data, w[31:0]);
        end else begin
            chk("hold_rd", {27'd0, bus.rd}, {27'd0, m_rd});
            chk("hold_data", bus.data, m_data);
        end
        chk("busy", bus.busy, m_busy);
        chk("sb_err", {31'd0, bus.sb_err}, {31'd0, m_err});
    endtask

    initial begin
        vec_t idle;
        idle = mk(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);

        // Issue/ALU commit of rd=5
        vecs.push_back(mk(1'b1, 5'd5, 5'd1, 5'd2, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0));
        vecs.push_back(mk(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0));
        vecs.push_back(idle);
        // RAW stall on x7 until its commit
        vecs.push_back(mk(1'b1, 5'd7, 5'd0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0));
        vecs.push_back(mk(1'b1, 5'd8, 5'd7, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0));
        vecs.push_back(mk(1'b1, 5'd8, 5'd7, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0));
        vecs.push_back(mk(1'b1, 5'd8, 5'd7, 5'd0, 1'b1, 5'd7, 32'h00000077, 1'b0, 5'd0, 32'd0));
        vecs.push_back(mk(1'b1, 5'd8, 5'd7, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0));
        vecs.push_back(idle);
        vecs.push_back(mk(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 5'd8, 32'h00000088, 1'b0, 5'd0, 32'd0));
        // ALU and load in the same cycle; rs2 hazard
        vecs.push_back(mk(1'b1, 5'd3, 5'd0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0));
        vecs.push_back(mk(1'b1, 5'd20, 5'd0, 5'd3, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0));
        vecs.push_back(mk(1'b1, 5'd4, 5'd0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0));
        vecs.push_back(mk(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 5'd3, 32'h00000033, 1'b1, 5'd4, 32'h00000044));
        vecs.push_back(idle);
        vecs.push_back(idle);
        // Busy ALU starves loads; FIFO fills and then drains in order
        vecs.push_back(mk(1'b1, 5'd10, 5'd0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0));
        vecs.push_back(mk(1'b1, 5'd11, 5'd0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0));
        vecs.push_back(mk(1'b1, 5'd12, 5'd0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0));
        vecs.push_back(mk(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 5'd0, 32'd1, 1'b1, 5'd10, 32'h000000A0));
        vecs.push_back(mk(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 5'd0, 32'd1, 1'b1, 5'd11, 32'h000000B0));
        vecs.push_back(mk(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 5'd0, 32'd1, 1'b1, 5'd12, 32'h000000C0));
        vecs.push_back(mk(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 5'd0, 32'd1, 1'b1, 5'd12, 32'h000000C0));
        vecs.push_back(mk(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd12, 32'h000000C0));
        vecs.push_back(mk(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd12, 32'h000000C0));
        vecs.push_back(idle);
        vecs.push_back(idle);
        // x0 issue, unexpected write, set-wins overlap
        vecs.push_back(mk(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0));
        vecs.push_back(mk(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 5'd9, 32'h00000099, 1'b0, 5'd0, 32'd0));
        vecs.push_back(mk(1'b1, 5'd13, 5'd0, 5'd0, 1'b1, 5'd13, 32'h0000000D, 1'b0, 5'd0, 32'd0));
        vecs.push_back(mk(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 5'd13, 32'h000000DD, 1'b0, 5'd0, 32'd0));
        vecs.push_back(idle);

        // Power-on reset
        apply(idle);
        rst = 1'b0;
        model_reset();
        #12;
        chk("rst_we", {31'd0, bus.WriteEnable}, 32'd0);
        chk("rst_rd", {27'd0, bus.rd}, 32'd0);
        chk("rst_data", bus.data, 32'd0);
        chk("rst_busy", bus.busy, 32'd0);
        chk("rst_sb_err", {31'd0, bus.sb_err}, 32'd0);
        chk("rst_ready", {31'd0, bus.mem_wb_ready}, 32'd1);
        #10;
        rst = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i]);
            tick();
        end
        chk("sb_err_sticky", {31'd0, bus.sb_err}, 32'd1);

        // Reset mid-cycle with two queued loads
        apply(mk(1'b1, 5'd14, 5'd0, 5'd0, 1'b1, 5'd0, 32'd1, 1'b1, 5'd14, 32'h000000E0));
        tick();
        apply(mk(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 5'd0, 32'd1, 1'b1, 5'd15, 32'h000000F0));
        tick();
        chk("pre_rst_full", {31'd0, bus.mem_wb_ready}, 32'd0);
        apply(mk(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 5'd0, 32'd1, 1'b0, 5'd0, 32'd0));
        #2;
        rst = 1'b0;
        #1;
        chk("midrst_we", {31'd0, bus.WriteEnable}, 32'd0);
        chk("midrst_rd", {27'd0, bus.rd}, 32'd0);
        chk("midrst_data", bus.data, 32'd0);
        chk("midrst_busy", bus.busy, 32'd0);
        chk("midrst_sb_err", {31'd0, bus.sb_err}, 32'd0);
        chk("midrst_ready", {31'd0, bus.mem_wb_ready}, 32'd1);
        model_reset();
        apply(idle);
        @(posedge clk);
        #2;
        rst = 1'b1;
        apply(mk(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 5'd1, 32'h00001234, 1'b0, 5'd0, 32'd0));
        tick();
        chk("first_commit_data", bus.data, 32'h00001234);
        apply(idle);
        tick();
        tick();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
